systolic_input_skewer: RTL and testbench

Parametrised activation feeder for a ROWS-row systolic array. It captures one ROWS×DEPTH activation tile through a valid/ready handshake and streams it out diagonally skewed: row r is delayed by r cycles, and zeros are inserted before and after each row's DEPTH elements. It sits between the activation buffer and the array's west edge. It supports arbitrary tile size, back-to-back tiles without bubbles, and a stall input.

---
 rtl/systolic_pkg.sv | 21 ++
 rtl/skew_lane.sv | 23 ++
 rtl/systolic_input_skewer.sv | 99 +++++++++
 tb/tb_systolic_input_skewer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array feeders: stream FSM states and
// beat/counter sizing derived from the tile geometry.
package systolic_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // A diagonally skewed tile occupies rows+depth-1 beats.
  function automatic int beats_of(input int rows, input int depth);
    return rows + depth - 1;
  endfunction

  function automatic int cnt_w_of(input int rows, input int depth);
    int b;
    b = rows + depth - 1;
    return (b < 2) ? 1 : $clog2(b);
  endfunction

endpackage

// File: rtl/skew_lane.sv
// One output lane of the skewer: picks row element (t - lane) when it falls
// inside the row, otherwise drives zero.
module skew_lane
  import systolic_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 1
) (
  input  logic [DEPTH*DATA_W-1:0] row,
  input  logic [CNT_W-1:0]        t,
  input  logic [CNT_W-1:0]        lane,
  output logic [DATA_W-1:0]       elem
);

  always_comb begin
    elem = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (int'(t) == int'(lane) + k) elem = row[k*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/systolic_input_skewer.sv
// Activation feeder: captures a ROWS x DEPTH tile and streams it out with
// row r delayed by r beats, zero-padded, one registered beat per cycle.
module systolic_input_skewer
  import systolic_pkg::*;
#(
  parameter int ROWS   = 2,
  parameter int DEPTH  = 2,
  parameter int DATA_W = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ROWS*DEPTH*DATA_W-1:0] in_data,
  input  logic                         hold,
  output logic                         out_valid,
  output logic [ROWS*DATA_W-1:0]       out_data,
  output logic                         out_last,
  output logic                         busy
);

  localparam int BEATS = beats_of(ROWS, DEPTH);
  localparam int CNT_W = cnt_w_of(ROWS, DEPTH);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_t                       state;
  logic [CNT_W-1:0]             beat_p0;
  logic [ROWS*DEPTH*DATA_W-1:0] tile_p0;
  logic [ROWS*DATA_W-1:0]       lanes;
  logic [ROWS*DATA_W-1:0]       data_p1;
  logic                         vld_p1;
  logic                         last_p1;
  logic                         at_last;

  // Stage p0: captured tile and beat index feed the per-row selectors.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    skew_lane #(
      .DEPTH (DEPTH),
      .DATA_W(DATA_W),
      .CNT_W (CNT_W)
    ) u_lane (
      .row (tile_p0[r*DEPTH*DATA_W +: DEPTH*DATA_W]),
      .t   (beat_p0),
      .lane(CNT_W'(r)),
      .elem(lanes[r*DATA_W +: DATA_W])
    );
  end

  assign at_last = (beat_p0 == LAST_BEAT);

  // Accepting while the last beat is being registered lets tiles run back to back.
  assign in_ready = (state == IDLE) || ((state == STREAM) && at_last && !hold);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      beat_p0 <= '0;
      tile_p0 <= '0;
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          data_p1 <= '0;
          vld_p1  <= 1'b0;
          last_p1 <= 1'b0;
          if (in_valid) begin
            tile_p0 <= in_data;
            beat_p0 <= '0;
            state   <= STREAM;
          end
        end
        STREAM: begin
          if (!hold) begin
            // Stage p1: registered skewed beat.
            data_p1 <= lanes;
            vld_p1  <= 1'b1;
            last_p1 <= at_last;
            if (at_last) begin
              beat_p0 <= '0;
              if (in_valid) tile_p0 <= in_data;
              else          state   <= IDLE;
            end else begin
              beat_p0 <= beat_p0 + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_last  = last_p1;
  assign busy      = (state == STREAM) || vld_p1;

endmodule

// File: tb/tb_systolic_input_skewer.sv
// Scoreboard bench for systolic_input_skewer: a 4x3 instance under random and
// directed traffic, plus directed 2x2 and 1x1 instances for corner geometries.
module tb_systolic_input_skewer;

  localparam int R = 4;
  localparam int D = 3;
  localparam int W = 16;
  localparam int B = R + D - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, in_valid, hold;
  logic [R*D*W-1:0] in_data;
  logic             in_ready, out_valid, out_last, busy;
  logic [R*W-1:0]   out_data;

  systolic_input_skewer #(.ROWS(R), .DEPTH(D), .DATA_W(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .hold(hold), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  logic        s_reset, s_valid, s_ready, s_hold, s_ovalid, s_olast, s_busy;
  logic [63:0] s_data;
  logic [31:0] s_out;

  systolic_input_skewer #(.ROWS(2), .DEPTH(2), .DATA_W(16)) dut_s (
    .clk(clk), .reset(s_reset), .in_valid(s_valid), .in_ready(s_ready),
    .in_data(s_data), .hold(s_hold), .out_valid(s_ovalid), .out_data(s_out),
    .out_last(s_olast), .busy(s_busy)
  );

  logic         u_reset, u_valid, u_ready, u_hold, u_ovalid, u_olast, u_busy;
  logic [W-1:0] u_data, u_out;

  systolic_input_skewer #(.ROWS(1), .DEPTH(1), .DATA_W(W)) dut_u (
    .clk(clk), .reset(u_reset), .in_valid(u_valid), .in_ready(u_ready),
    .in_data(u_data), .hold(u_hold), .out_valid(u_ovalid), .out_data(u_out),
    .out_last(u_olast), .busy(u_busy)
  );

  int checks = 0;
  int errors = 0;
  bit done_s = 1'b0;
  bit done_u = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic [R*W-1:0] data;
    logic           last;
  } beat_t;

  beat_t exp_q[$];

  // Reference: beat t, lane r carries A[r][t-r] when that index is in range.
  function automatic void push_tile(input logic [R*D*W-1:0] tile);
    for (int t = 0; t < B; t++) begin
      beat_t b;
      b.data = '0;
      for (int r = 0; r < R; r++) begin
        int k;
        k = t - r;
        if (k >= 0 && k < D) b.data[r*W +: W] = tile[(r*D+k)*W +: W];
      end
      b.last = (t == B - 1);
      exp_q.push_back(b);
    end
  endfunction

  function automatic logic [R*D*W-1:0] rand_tile();
    logic [R*D*W-1:0] v;
    for (int i = 0; i < R*D; i++) v[i*W +: W] = W'($urandom);
    return v;
  endfunction

  // Monitor: a new beat appears on every valid cycle not preceded by a held edge.
  logic           hold_edge = 1'b0;
  logic [R*W-1:0] prev_data;
  logic           prev_last;
  always @(posedge clk) hold_edge <= hold;

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (hold_edge) begin
        chk("frozen_data", out_data, prev_data);
        chk("frozen_last", out_last, prev_last);
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %0h expected no beat", out_data);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat_data", out_data, e.data);
        chk("beat_last", out_last, e.last);
        chk("beat_busy", busy, 1);
      end
    end
    prev_data = out_data;
    prev_last = out_last;
  end

  task automatic offer(input logic [R*D*W-1:0] tile, input bit rnd_hold, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    while (!ok) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = tile;
      hold     = rnd_hold ? ($urandom_range(0, 3) == 0) : 1'b0;
      #4;
      ok = in_ready;
      @(posedge clk);
      if (ok) push_tile(tile);
      else begin
        waited++;
        if (waited > 200) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout: got no in_ready in %0d cycles expected acceptance", waited);
          ok = 1'b1;
        end
      end
    end
  endtask

  task automatic idle(input int n, input bit rnd_hold);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = rand_tile();
      hold     = rnd_hold ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    @(negedge clk);
    in_valid = 1'b0;
    hold     = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    @(negedge clk);
    chk("idle_valid", out_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_ready", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : main
    logic [R*D*W-1:0] tile;
    int w, cnt;
    bit gap;
    reset = 1'b1; in_valid = 1'b0; hold = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);

    // Tile with values r*10+k.
    for (int r = 0; r < R; r++)
      for (int k = 0; k < D; k++) tile[(r*D+k)*W +: W] = W'(r*10 + k);
    offer(tile, 1'b0, w);
    drain();

    // Back-to-back tiles with the second held valid throughout.
    offer(rand_tile(), 1'b0, w);
    offer(rand_tile(), 1'b0, w);
    chk("b2b_wait", w, B - 1);
    gap = 1'b0;
    for (int c = 0; c <= B; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = rand_tile();
      if (out_valid !== 1'b1 || busy !== 1'b1) gap = 1'b1;
    end
    chk("b2b_no_bubble", gap, 0);
    drain();

    // Three-cycle hold on beat 1.
    offer(rand_tile(), 1'b0, w);
    cnt = 0;
    for (int c = 0; c < 3*B; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = rand_tile();
      if (out_valid === 1'b1) cnt++;
      if (c == 2) hold = 1'b1;
      if (c == 5) hold = 1'b0;
      if (hold) begin
        #1;
        chk("hold_ready", in_ready, 0);
      end
    end
    chk("hold_len", cnt, B + 3);
    drain();

    // Reset mid-stream on beat 1, then a fresh tile.
    offer(rand_tile(), 1'b0, w);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    reset = 1'b0;
    offer(rand_tile(), 1'b0, w);
    drain();

    // Random traffic with random holds and gaps.
    for (int i = 0; i < 30; i++) begin
      offer(rand_tile(), 1'b1, w);
      idle($urandom_range(0, 2), 1'b1);
    end
    drain();

    wait (done_s && done_u);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : small_2x2
    logic [31:0] e [3];
    e[0] = 32'h0000_0001;
    e[1] = 32'h0003_0002;
    e[2] = 32'h0004_0000;
    s_reset = 1'b1; s_valid = 1'b0; s_hold = 1'b0; s_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    s_reset = 1'b0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = {16'd4, 16'd3, 16'd2, 16'd1};
    #4;
    chk("s_ready_idle", s_ready, 1);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    s_data  = '1;
    chk("s_pre_valid", s_ovalid, 0);
    chk("s_busy_start", s_busy, 1);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk("s_beat_data", s_out, e[t]);
      chk("s_beat_valid", s_ovalid, 1);
      chk("s_beat_last", s_olast, (t == 2));
    end
    @(negedge clk);
    chk("s_end_valid", s_ovalid, 0);
    chk("s_end_data", s_out, 0);
    chk("s_end_ready", s_ready, 1);
    chk("s_end_busy", s_busy, 0);
    done_s = 1'b1;
  end

  initial begin : single_1x1
    logic [W-1:0] dv [6];
    u_reset = 1'b1; u_valid = 1'b0; u_hold = 1'b0; u_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    u_reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        chk("u_data", u_out, dv[i-2]);
        chk("u_last", u_olast, 1);
        chk("u_valid", u_ovalid, 1);
      end
      if (i < 6) begin
        dv[i]   = W'($urandom);
        u_valid = 1'b1;
        u_data  = dv[i];
        #1;
        chk("u_ready", u_ready, 1);
      end else begin
        u_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("u_end_valid", u_ovalid, 0);
    chk("u_end_busy", u_busy, 0);
    done_u = 1'b1;
  end

endmodule
